// File: rtl/size_seq_pkg.sv
// Shared definitions for the size sequencer and the size accumulator:
// command codes, size1 op codes and the sequencer state encoding.
package size_seq_pkg;

    localparam int CMD_W_DEF = 3;

    localparam logic [2:0] CMD_START  = 3'd0;
    localparam logic [2:0] CMD_FIRST  = 3'd1;
    localparam logic [2:0] CMD_DATA   = 3'd2;
    localparam logic [2:0] CMD_EXT    = 3'd3;
    localparam logic [2:0] CMD_FINISH = 3'd4;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_EXT  = 2'b10;
    localparam logic [1:0] OP_PAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PAD   = 2'd2,
        ST_CAPT  = 2'd3
    } state_e;

    // FIRST loads size1 with the chunk length, DATA accumulates it.
    function automatic logic [1:0] chunk_op(input logic [2:0] code);
        logic [1:0] op;
        case (code)
            CMD_FIRST: op = OP_LOAD;
            CMD_DATA:  op = OP_ADD;
            default:   op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/size_seq_if.sv
// Descriptor handshake between the SPI decoder (master) and the size
// sequencer (slave).
interface size_seq_if
    import size_seq_pkg::*;
#(
    parameter int CMD_W = CMD_W_DEF
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_code;
    logic [15:0]      cmd_len;
    logic             cmd_mode384;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_len,
        output cmd_mode384,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_len,
        input  cmd_mode384,
        output cmd_ready
    );

endinterface

// File: rtl/size_seq.sv
// Command sequencer driving the size0/size1 accumulator strobes and capturing
// the final sizes. Optional SIZE_SEQ_CNT_EN adds a saturating chunk counter.
module size_seq
    import size_seq_pkg::*;
#(
    parameter logic [15:0] MAX_CHUNK = 16'd4096,
    parameter int          CMD_W     = CMD_W_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    size_seq_if.slave   cmd,
    input  logic [31:0] size0,
    input  logic [31:0] size1,
    output logic [15:0] wr_size,
    output logic [15:0] cmd_extend,
    output logic        s1_flg_384,
    output logic        size0_clr,
    output logic        size0_add,
    output logic        size1_clr,
    output logic        size1_en,
    output logic [1:0]  size1_op,
    output logic [31:0] tot0,
    output logic [31:0] tot1,
    output logic        done,
    output logic        err,
    output logic        busy
`ifdef SIZE_SEQ_CNT_EN
    ,
    output logic [15:0] chunk_cnt
`endif
);

    state_e           state_r;
    state_e           next_state_s;
    logic [CMD_W-1:0] code_s;
    logic             accept_s;
    logic             len_ok_s;

    logic [15:0] wr_size_s;
    logic [15:0] cmd_extend_s;
    logic        flg_s;
    logic        size0_clr_s;
    logic        size0_add_s;
    logic        size1_clr_s;
    logic        size1_en_s;
    logic [1:0]  size1_op_s;
    logic [31:0] tot0_s;
    logic [31:0] tot1_s;
    logic        done_s;
    logic        err_s;
    logic        busy_s;
    logic        ready_s;
`ifdef SIZE_SEQ_CNT_EN
    logic [15:0] cnt_s;
`endif

    assign code_s   = cmd.cmd_code;
    assign accept_s = cmd.cmd_valid && cmd.cmd_ready;
    assign len_ok_s = (cmd.cmd_len <= MAX_CHUNK);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (code_s == CMD_START)) begin
                    next_state_s = ST_ACCUM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && (code_s == CMD_FINISH)) begin
                    next_state_s = ST_PAD;
                end else begin
                    next_state_s = ST_ACCUM;
                end
            end
            ST_PAD:  next_state_s = ST_CAPT;
            ST_CAPT: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; strobes default low every cycle.
    always_comb begin
        wr_size_s    = wr_size;
        cmd_extend_s = cmd_extend;
        flg_s        = s1_flg_384;
        size0_clr_s  = 1'b0;
        size0_add_s  = 1'b0;
        size1_clr_s  = 1'b0;
        size1_en_s   = 1'b0;
        size1_op_s   = OP_LOAD;
        tot0_s       = tot0;
        tot1_s       = tot1;
        done_s       = 1'b0;
        err_s        = err;
        // ready/busy track the state the FSM is about to enter
        ready_s      = (next_state_s == ST_IDLE) || (next_state_s == ST_ACCUM);
        busy_s       = (next_state_s != ST_IDLE);
`ifdef SIZE_SEQ_CNT_EN
        cnt_s        = chunk_cnt;
`endif
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (code_s == CMD_START) begin
                        size0_clr_s = 1'b1;
                        size1_clr_s = 1'b1;
                        flg_s       = cmd.cmd_mode384;
`ifdef SIZE_SEQ_CNT_EN
                        cnt_s       = 16'd0;
`endif
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    err_s = err;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    case (code_s)
                        CMD_START: begin
                            size0_clr_s = 1'b1;
                            size1_clr_s = 1'b1;
                            flg_s       = cmd.cmd_mode384;
`ifdef SIZE_SEQ_CNT_EN
                            cnt_s       = 16'd0;
`endif
                        end
                        CMD_FIRST, CMD_DATA: begin
                            if (len_ok_s) begin
                                wr_size_s   = cmd.cmd_len;
                                size0_add_s = 1'b1;
                                size1_en_s  = 1'b1;
                                size1_op_s  = chunk_op(code_s);
`ifdef SIZE_SEQ_CNT_EN
                                cnt_s = (chunk_cnt == 16'hFFFF) ? chunk_cnt : (chunk_cnt + 16'd1);
`endif
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        CMD_EXT: begin
                            if (len_ok_s) begin
                                cmd_extend_s = cmd.cmd_len;
                                size1_en_s   = 1'b1;
                                size1_op_s   = OP_EXT;
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        CMD_FINISH: begin
                            size1_en_s = 1'b1;
                            size1_op_s = OP_PAD;
                        end
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    err_s = err;
                end
            end
            ST_PAD: begin
                done_s = 1'b0;
            end
            ST_CAPT: begin
                tot0_s = size0;
                tot1_s = size1;
                done_s = 1'b1;
            end
            default: begin
                done_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_size       <= 16'd0;
            cmd_extend    <= 16'd0;
            s1_flg_384    <= 1'b0;
            size0_clr     <= 1'b0;
            size0_add     <= 1'b0;
            size1_clr     <= 1'b0;
            size1_en      <= 1'b0;
            size1_op      <= OP_LOAD;
            tot0          <= 32'd0;
            tot1          <= 32'd0;
            done          <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            cmd.cmd_ready <= 1'b1;
`ifdef SIZE_SEQ_CNT_EN
            chunk_cnt     <= 16'd0;
`endif
        end else begin
            wr_size       <= wr_size_s;
            cmd_extend    <= cmd_extend_s;
            s1_flg_384    <= flg_s;
            size0_clr     <= size0_clr_s;
            size0_add     <= size0_add_s;
            size1_clr     <= size1_clr_s;
            size1_en      <= size1_en_s;
            size1_op      <= size1_op_s;
            tot0          <= tot0_s;
            tot1          <= tot1_s;
            done          <= done_s;
            err           <= err_s;
            busy          <= busy_s;
            cmd.cmd_ready <= ready_s;
`ifdef SIZE_SEQ_CNT_EN
            chunk_cnt     <= cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_size_seq.sv
// Directed testbench for size_seq with a small behavioural size accumulator.
module tb_size_seq;

    localparam logic [2:0] C_START  = 3'd0;
    localparam logic [2:0] C_FIRST  = 3'd1;
    localparam logic [2:0] C_DATA   = 3'd2;
    localparam logic [2:0] C_EXT    = 3'd3;
    localparam logic [2:0] C_FINISH = 3'd4;

    logic        clk;
    logic        rst;
    logic [31:0] acc0;
    logic [31:0] acc1;
    logic [15:0] wr_size;
    logic [15:0] cmd_extend;
    logic        s1_flg_384;
    logic        size0_clr;
    logic        size0_add;
    logic        size1_clr;
    logic        size1_en;
    logic [1:0]  size1_op;
    logic [31:0] tot0;
    logic [31:0] tot1;
    logic        done;
    logic        err;
    logic        busy;
`ifdef SIZE_SEQ_CNT_EN
    logic [15:0] chunk_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    size_seq_if bus ();

    size_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .size0      (acc0),
        .size1      (acc1),
        .wr_size    (wr_size),
        .cmd_extend (cmd_extend),
        .s1_flg_384 (s1_flg_384),
        .size0_clr  (size0_clr),
        .size0_add  (size0_add),
        .size1_clr  (size1_clr),
        .size1_en   (size1_en),
        .size1_op   (size1_op),
        .tot0       (tot0),
        .tot1       (tot1),
        .done       (done),
        .err        (err),
        .busy       (busy)
`ifdef SIZE_SEQ_CNT_EN
        ,
        .chunk_cnt  (chunk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural accumulator: padding adds a fixed 32 for this bench.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc0 <= 32'd0;
            acc1 <= 32'd0;
        end else begin
            if (size0_clr) acc0 <= 32'd0;
            else if (size0_add) acc0 <= acc0 + {16'd0, wr_size};
            if (size1_clr) acc1 <= 32'd0;
            else if (size1_en) begin
                case (size1_op)
                    2'b00:   acc1 <= {16'd0, wr_size};
                    2'b01:   acc1 <= acc1 + {16'd0, wr_size};
                    2'b10:   acc1 <= acc1 + {16'd0, cmd_extend};
                    default: acc1 <= acc1 + 32'd32;
                endcase
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic issue(input logic [2:0] code, input logic [15:0] len, input logic mode);
        bus.cmd_valid   = 1'b1;
        bus.cmd_code    = code;
        bus.cmd_len     = len;
        bus.cmd_mode384 = mode;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_code = C_START;
        bus.cmd_len = 16'd7;
        bus.cmd_mode384 = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({size0_clr, size0_add, size1_clr, size1_en, done, err, busy, s1_flg_384} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {size0_clr, size0_add, size1_clr, size1_en, done, err, busy, s1_flg_384});
        end
        n_vec++;
        if ({wr_size, cmd_extend, tot0, tot1, size1_op} !== 98'd0) begin
            n_bad++;
            $display("FAIL reset_data: wr=%h ext=%h t0=%h t1=%h op=%b want all 0",
                     wr_size, cmd_extend, tot0, tot1, size1_op);
        end
        n_vec++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        issue(C_START, 16'd0, 1'b1);
        n_vec++;
        if ({size0_clr, size0_add, size1_clr, size1_en, s1_flg_384, busy} !== 6'b101011) begin
            n_bad++;
            $display("FAIL start_strobes: got %b want 101011",
                     {size0_clr, size0_add, size1_clr, size1_en, s1_flg_384, busy});
        end
        @(negedge clk);
        n_vec++;
        if ({size0_clr, size1_clr, s1_flg_384} !== 3'b001) begin
            n_bad++;
            $display("FAIL start_single_cycle: got %b want 001", {size0_clr, size1_clr, s1_flg_384});
        end
    endtask

    task automatic test_main_flow();
        do_reset();
        issue(C_START, 16'd0, 1'b0);
        issue(C_FIRST, 16'd100, 1'b0);
        n_vec++;
        if ({size0_clr, size0_add, size1_clr, size1_en, size1_op, wr_size} !== {4'b0101, 2'b00, 16'd100}) begin
            n_bad++;
            $display("FAIL first: strb=%b op=%b wr=%0d want 0101/00/100",
                     {size0_clr, size0_add, size1_clr, size1_en}, size1_op, wr_size);
        end
        issue(C_DATA, 16'd200, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, size1_op, wr_size} !== {2'b11, 2'b01, 16'd200}) begin
            n_bad++;
            $display("FAIL data: strb=%b op=%b wr=%0d want 11/01/200",
                     {size0_add, size1_en}, size1_op, wr_size);
        end
        issue(C_EXT, 16'd16, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, size1_op, cmd_extend, wr_size} !== {2'b01, 2'b10, 16'd16, 16'd200}) begin
            n_bad++;
            $display("FAIL ext: strb=%b op=%b ext=%0d wr=%0d want 01/10/16/200",
                     {size0_add, size1_en}, size1_op, cmd_extend, wr_size);
        end
        issue(C_FINISH, 16'd0, 1'b0);
        n_vec++;
        if ({size1_en, size1_op, done, bus.cmd_ready, busy} !== 6'b111001) begin
            n_bad++;
            $display("FAIL finish_c1: got %b want 111001", {size1_en, size1_op, done, bus.cmd_ready, busy});
        end
        @(negedge clk);
        n_vec++;
        if ({size1_en, done, bus.cmd_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL finish_c2: got %b want 000", {size1_en, done, bus.cmd_ready});
        end
        @(negedge clk);
        n_vec++;
        if ({done, tot0, tot1} !== {1'b1, 32'd300, 32'd348}) begin
            n_bad++;
            $display("FAIL finish_c3: done=%b tot0=%0d tot1=%0d want 1/300/348", done, tot0, tot1);
        end
        @(negedge clk);
        n_vec++;
        if ({done, busy, tot0, tot1} !== {2'b00, 32'd300, 32'd348}) begin
            n_bad++;
            $display("FAIL finish_c4: done=%b busy=%b tot0=%0d tot1=%0d want 0/0/300/348",
                     done, busy, tot0, tot1);
        end
    endtask

    task automatic test_len_check();
        do_reset();
        issue(C_START, 16'd0, 1'b0);
        issue(C_DATA, 16'd4097, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, err} !== 3'b001) begin
            n_bad++;
            $display("FAIL len_over: got %b want 001", {size0_add, size1_en, err});
        end
        issue(C_DATA, 16'd10, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, size1_op, wr_size, err} !== {2'b11, 2'b01, 16'd10, 1'b1}) begin
            n_bad++;
            $display("FAIL len_next: strb=%b op=%b wr=%0d err=%b want 11/01/10/1",
                     {size0_add, size1_en}, size1_op, wr_size, err);
        end
        issue(C_DATA, 16'd4096, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, wr_size} !== {2'b11, 16'd4096}) begin
            n_bad++;
            $display("FAIL len_max: strb=%b wr=%0d want 11/4096", {size0_add, size1_en}, wr_size);
        end
        issue(C_FIRST, 16'd0, 1'b0);
        n_vec++;
        if ({size0_add, size1_en, size1_op, wr_size} !== {2'b11, 2'b00, 16'd0}) begin
            n_bad++;
            $display("FAIL len_zero: strb=%b op=%b wr=%0d want 11/00/0",
                     {size0_add, size1_en}, size1_op, wr_size);
        end
        issue(C_EXT, 16'd5000, 1'b0);
        n_vec++;
        if ({size1_en, cmd_extend} !== {1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL ext_over: en=%b ext=%0d want 0/0", size1_en, cmd_extend);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        issue(C_DATA, 16'd5, 1'b0);
        n_vec++;
        if ({size0_clr, size0_add, size1_clr, size1_en, err, busy, bus.cmd_ready} !== 7'b0000101) begin
            n_bad++;
            $display("FAIL idle_data: got %b want 0000101",
                     {size0_clr, size0_add, size1_clr, size1_en, err, busy, bus.cmd_ready});
        end
        do_reset();
        issue(C_START, 16'd0, 1'b0);
        issue(3'd6, 16'd5, 1'b0);
        n_vec++;
        if ({size0_clr, size0_add, size1_clr, size1_en, err, busy, bus.cmd_ready} !== 7'b0000111) begin
            n_bad++;
            $display("FAIL accum_code6: got %b want 0000111",
                     {size0_clr, size0_add, size1_clr, size1_en, err, busy, bus.cmd_ready});
        end
        issue(C_START, 16'd0, 1'b0);
        n_vec++;
        if ({size0_clr, err} !== 2'b11) begin
            n_bad++;
            $display("FAIL err_sticky: got %b want 11", {size0_clr, err});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(C_START, 16'd0, 1'b0);
        issue(C_FIRST, 16'd5, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_code = C_FINISH;
        bus.cmd_len = 16'd0;
        bus.cmd_mode384 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_code = C_START;
        bus.cmd_mode384 = 1'b1;
        n_vec++;
        if ({bus.cmd_ready, size1_en, size1_op} !== 4'b0111) begin
            n_bad++;
            $display("FAIL hold_pad: got %b want 0111", {bus.cmd_ready, size1_en, size1_op});
        end
        @(negedge clk);
        n_vec++;
        if ({bus.cmd_ready, size0_clr, size1_clr, size1_en} !== 4'b0000) begin
            n_bad++;
            $display("FAIL hold_capt: got %b want 0000", {bus.cmd_ready, size0_clr, size1_clr, size1_en});
        end
        @(negedge clk);
        n_vec++;
        if ({done, bus.cmd_ready, size0_clr, tot0, tot1} !== {3'b110, 32'd5, 32'd37}) begin
            n_bad++;
            $display("FAIL hold_done: done=%b rdy=%b clr=%b tot0=%0d tot1=%0d want 1/1/0/5/37",
                     done, bus.cmd_ready, size0_clr, tot0, tot1);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_vec++;
        if ({size0_clr, size1_clr, s1_flg_384, busy, done} !== 5'b11110) begin
            n_bad++;
            $display("FAIL hold_start: got %b want 11110", {size0_clr, size1_clr, s1_flg_384, busy, done});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(C_START, 16'd0, 1'b1);
        issue(C_DATA, 16'd9, 1'b0);
        issue(C_FINISH, 16'd0, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, size1_en, s1_flg_384, wr_size, bus.cmd_ready} !== {3'b000, 16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_mid: busy=%b en=%b flg=%b wr=%0d rdy=%b want 0/0/0/0/1",
                     busy, size1_en, s1_flg_384, wr_size, bus.cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_vec++;
            if ({done, busy, tot0, tot1} !== 66'd0) begin
                n_bad++;
                $display("FAIL rst_no_done: done=%b busy=%b tot0=%0d tot1=%0d want 0", done, busy, tot0, tot1);
            end
        end
    endtask

`ifdef SIZE_SEQ_CNT_EN
    task automatic test_chunk_cnt();
        do_reset();
        issue(C_START, 16'd0, 1'b0);
        issue(C_DATA, 16'd1, 1'b0);
        issue(C_DATA, 16'd2, 1'b0);
        issue(C_DATA, 16'd3, 1'b0);
        issue(C_DATA, 16'd5000, 1'b0);
        issue(C_EXT, 16'd4, 1'b0);
        n_vec++;
        if (chunk_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL cnt_three: got %0d want 3", chunk_cnt);
        end
        issue(C_START, 16'd0, 1'b0);
        n_vec++;
        if (chunk_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL cnt_start: got %0d want 0", chunk_cnt);
        end
        issue(C_FIRST, 16'd8, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({chunk_cnt, wr_size, size0_add, size1_en, busy} !== 35'd0) begin
            n_bad++;
            $display("FAIL cnt_rst: cnt=%0d wr=%0d strb=%b busy=%b want 0",
                     chunk_cnt, wr_size, {size0_add, size1_en}, busy);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_code = 3'd0;
        bus.cmd_len = 16'd0;
        bus.cmd_mode384 = 1'b0;
        test_reset();
        test_main_flow();
        test_len_check();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef SIZE_SEQ_CNT_EN
        test_chunk_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/size_seq.md
Name: size_seq

Overview:
- Command-driven sequencer directly upstream of the size accumulator (size0/size1 block).
- Accepts decoded SPI size descriptors over a valid/ready handshake and drives the accumulator's registered clear, add and op strobes.
- After a FINISH command, captures the accumulator's final size0/size1 into total registers and pulses done.

Parameters:
- MAX_CHUNK, 16'd4096, largest legal chunk length; larger lengths are errors.
- CMD_W, 3, width of the command code.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  descriptor valid
- cmd_ready  output  1  descriptor accepted when valid&&ready at posedge clk
- cmd_code  input  CMD_W  command: 0 START, 1 FIRST, 2 DATA, 3 EXT, 4 FINISH; 5-7 illegal
- cmd_len  input  16  chunk/extend length
- cmd_mode384  input  1  hash mode for START (1 = 384-type padding)
- size0  input  32  accumulator size0 feedback
- size1  input  32  accumulator size1 feedback
- wr_size  output  16  length to accumulator
- cmd_extend  output  16  extend length to accumulator
- s1_flg_384  output  1  padding select, latched at START
- size0_clr, size0_add  output  1 each  size0 strobes
- size1_clr, size1_en  output  1 each  size1 strobes
- size1_op  output  2  00 load, 01 add wr_size, 10 add cmd_extend, 11 add pad
- tot0, tot1  output  32 each  captured final sizes
- done  output  1  one-cycle pulse, totals valid
- err  output  1  sticky protocol error
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all strobes 0; wr_size, cmd_extend, tot0, tot1 = 0; s1_flg_384 = 0; done = 0; err = 0; size1_op = 00.
- All outputs are registered. Strobes for a command accepted at edge E are high for exactly the cycle after E. The accumulator updates at E+1.
- States: IDLE, ACCUM, PAD, CAPT.
- cmd_ready = 1 in IDLE and ACCUM; 0 in PAD and CAPT.
- IDLE: START sets size0_clr=1 and size1_clr=1, latches s1_flg_384=cmd_mode384, goes to ACCUM. Any other code sets err and is dropped; state stays IDLE.
- ACCUM:
  - START: re-clear and re-latch the mode; stay in ACCUM.
  - FIRST: wr_size=cmd_len, size0_add=1, size1_en=1, op=00.
  - DATA: wr_size=cmd_len, size0_add=1, size1_en=1, op=01.
  - EXT: cmd_extend=cmd_len, size1_en=1, op=10; size0 untouched.
  - FINISH: size1_en=1, op=11; go to PAD.
  - Illegal code: set err, drop the command, stay in ACCUM.
- PAD: wait one cycle while the accumulator updates; go to CAPT.
- CAPT: sample size0/size1 into tot0/tot1; done=1 in the following cycle; go to IDLE.
  - done rises 3 cycles after the FINISH handshake edge.
- Length checks: for FIRST/DATA/EXT, cmd_len > MAX_CHUNK sets err, drops the command and emits no strobe. cmd_len = 0 is legal and emits a normal strobe.
- wr_size and cmd_extend hold their last value between commands; only the strobes are single-cycle.
- Clear and add strobes are never asserted in the same cycle.
- err clears only on reset. START does not clear err.
- tot0/tot1 hold until the next capture.
- Arithmetic wrap-around belongs to the accumulator; the sequencer does no arithmetic beyond compares.
- Reset mid-sequence returns to IDLE immediately; a done pulse in flight is suppressed.

Optional Feature:
- Macro: SIZE_SEQ_CNT_EN.
- Defined: adds output chunk_cnt [15:0].
  - Increments on each accepted FIRST/DATA.
  - Saturates at 16'hFFFF.
  - Cleared by START and by reset.
- Undefined: no chunk_cnt port and no counter logic.

Decomposition:
- Shared package size_seq_pkg:
  - command code localparams (CMD_START..CMD_FINISH);
  - size1_op codes (OP_LOAD, OP_ADD, OP_EXT, OP_PAD);
  - FSM state encoding.
- The accumulator also uses the op codes from this package.
- No sub-module; the block stays flat.

Test Plan:
- Reset with cmd_valid=1: outputs all zero, state IDLE, no strobes; release, then START mode384=1 -> cycle after: size0_clr=1, size1_clr=1, s1_flg_384=1.
- START(mode384=0), FIRST 100, DATA 200, EXT 16, FINISH, with a behavioural accumulator -> tot0=300, tot1=348, done pulses once, 3 cycles after the FINISH edge.
- DATA with cmd_len=4097 -> err=1, no size0_add/size1_en, next DATA 10 still accepted normally.
- DATA in IDLE, then code 6 in ACCUM -> err=1 both times, no strobes, cmd_ready stays 1.
- cmd_valid held through FINISH -> cmd_ready=0 in PAD and CAPT, no command lost; the held START is accepted in IDLE.
- SIZE_SEQ_CNT_EN defined: 3 DATA -> chunk_cnt=3; START -> 0; rst asserted mid-ACCUM -> all outputs zero next cycle.
